// File: rtl/memory_responder_if.sv
// Request/response bus between a cache-side master and the memory responder.
// The master drives block requests; the responder returns a one-cycle
// completion pulse with read data.
interface memory_responder_if #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
) ();
  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [BLOCK_WIDTH-1:0] mem_wdata;
  logic [BLOCK_WIDTH-1:0] mem_rdata;
  logic                   mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/memory_responder.sv
// Fixed-latency block memory model. A request is latched in IDLE, held for
// LATENCY cycles (BUSY counts down), then completed with a single RESP cycle
// in which mem_ready pulses. Protocol misuse is flagged on a sticky proto_err.
module memory_responder #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128,
  parameter int DEPTH_LOG2  = 8,
  parameter int LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_responder_if.slave      bus,
  output logic                   proto_err,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Counter preload; LATENCY=1 gives 0 and skips BUSY entirely.
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic                    op_write_reg, op_write_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [BLOCK_WIDTH-1:0]  wdata_reg, wdata_next;
  logic                    err_next;
  logic                    enter_resp;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   index;

  // Block storage; never reset, so unwritten blocks read as undefined.
  logic [BLOCK_WIDTH-1:0]  storage [2**DEPTH_LOG2];

  // Only the low address bits select a block; higher bits alias.
  assign index = addr_next[DEPTH_LOG2-1:0];

  // Next-state, request latching and protocol checking.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    op_write_next = op_write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    err_next      = proto_err;
    enter_resp    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          // Simultaneous read and write resolves to a write.
          op_write_next = bus.mem_write;
          addr_next     = bus.mem_addr;
          wdata_next    = bus.mem_wdata;
          if (bus.mem_read && bus.mem_write) begin
            err_next = 1'b1;
          end
          if (LOAD == 4'd0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = BUSY;
            count_next = LOAD;
          end
        end
      end
      BUSY: begin
        // Master must hold address and request line until completion;
        // violations are flagged but the latched transaction still runs.
        if ((bus.mem_addr != addr_reg) ||
            (op_write_reg ? !bus.mem_write : !bus.mem_read)) begin
          err_next = 1'b1;
        end
        if (count_reg <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
          count_next = 4'd0;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A write reaches storage only on the edge entering RESP, never under reset.
  assign wr_en = enter_resp && op_write_next && !rst;

  // FSM, latched request, registered response and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= 4'd0;
      op_write_reg  <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      proto_err     <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      rd_count      <= 16'd0;
      wr_count      <= 16'd0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      op_write_reg  <= op_write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      proto_err     <= err_next;
      bus.mem_ready <= enter_resp;
      // Read data is only driven during the ready pulse of a read.
      if (enter_resp && !op_write_next) begin
        bus.mem_rdata <= storage[index];
      end else begin
        bus.mem_rdata <= '0;
      end
      if (enter_resp && op_write_next && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (enter_resp && !op_write_next && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[index] <= wdata_next;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder at LATENCY 4, 1 and 15. Each request
// pushes its expected completion cycle and read data onto a per-instance
// queue; a monitor pops and compares whenever mem_ready pulses.
module tb_memory_responder;
  localparam int AW = 28;
  localparam int BW = 128;

  localparam logic [BW-1:0] D0 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [BW-1:0] D1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
  localparam logic [BW-1:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [BW-1:0] D3 = 128'hFFFFFFFF_FFFFFFFF_00000000_00000000;
  localparam logic [BW-1:0] D4 = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [BW-1:0] D5 = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
  localparam logic [BW-1:0] D6 = 128'h99990000_88880000_77770000_66660000;
  localparam logic [BW-1:0] D7 = 128'hBADC0FFE_E0DDF00D_8BADF00D_FEEDFACE;
  localparam logic [BW-1:0] D8 = 128'h00000000_00000000_00000000_0000ABCD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            rd;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb [3][$];

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int fails = 0;

  logic          req_rd    [3];
  logic          req_wr    [3];
  logic [AW-1:0] req_addr  [3];
  logic [BW-1:0] req_wdata [3];
  logic          ready     [3];
  logic [BW-1:0] rdata     [3];
  logic          perr      [3];
  logic [15:0]   rdc       [3];
  logic [15:0]   wrc       [3];

  memory_responder_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus0 ();
  memory_responder_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus1 ();
  memory_responder_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus2 ();

  assign bus0.mem_read  = req_rd[0];
  assign bus0.mem_write = req_wr[0];
  assign bus0.mem_addr  = req_addr[0];
  assign bus0.mem_wdata = req_wdata[0];
  assign ready[0]       = bus0.mem_ready;
  assign rdata[0]       = bus0.mem_rdata;
  assign bus1.mem_read  = req_rd[1];
  assign bus1.mem_write = req_wr[1];
  assign bus1.mem_addr  = req_addr[1];
  assign bus1.mem_wdata = req_wdata[1];
  assign ready[1]       = bus1.mem_ready;
  assign rdata[1]       = bus1.mem_rdata;
  assign bus2.mem_read  = req_rd[2];
  assign bus2.mem_write = req_wr[2];
  assign bus2.mem_addr  = req_addr[2];
  assign bus2.mem_wdata = req_wdata[2];
  assign ready[2]       = bus2.mem_ready;
  assign rdata[2]       = bus2.mem_rdata;

  memory_responder #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .DEPTH_LOG2(8), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .proto_err(perr[0]), .rd_count(rdc[0]), .wr_count(wrc[0])
  );
  memory_responder #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .DEPTH_LOG2(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .proto_err(perr[1]), .rd_count(rdc[1]), .wr_count(wrc[1])
  );
  memory_responder #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .DEPTH_LOG2(8), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .proto_err(perr[2]), .rd_count(rdc[2]), .wr_count(wrc[2])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: one scoreboard pop per mem_ready pulse; rdata must be
  // zero whenever ready is low, and a late completion is reported as missing.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ready[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          chk($sformatf("spurious_ready_u%0d", d), ready[d], 1'b0);
        end else begin
          exp_t e;
          e = sb[d].pop_front();
          chk($sformatf("ready_cycle_u%0d", d), cyc, e.cyc);
          if (e.rd) chk($sformatf("read_data_u%0d", d), rdata[d], e.data);
          $display("u%0d completion at cycle %0d (%s)", d, cyc, e.rd ? "read" : "write");
        end
      end else begin
        chk($sformatf("rdata_zero_u%0d", d), rdata[d], '0);
        if (sb[d].size() != 0 && cyc > sb[d][0].cyc) begin
          chk($sformatf("ready_missing_u%0d", d), ready[d], 1'b1);
          void'(sb[d].pop_front());
        end
      end
    end
  end

  // Issue one request (called #1 after a rising edge) and hold it until the
  // completion pulse; optionally change the address one cycle in.
  task automatic txn(input int d, input bit wr, input bit rd, input logic [AW-1:0] a,
                     input logic [BW-1:0] wd, input logic [BW-1:0] exp_rd,
                     input bit glitch, input logic [AW-1:0] glitch_a);
    exp_t e;
    req_rd[d]    = rd;
    req_wr[d]    = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    e.cyc  = cyc + lat(d);
    e.rd   = rd && !wr;
    e.data = exp_rd;
    sb[d].push_back(e);
    if (glitch) begin
      @(posedge clk); #1;
      req_addr[d] = glitch_a;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) break;
    end
    @(posedge clk); #1;
    req_rd[d] = 1'b0;
    req_wr[d] = 1'b0;
  endtask

  task automatic wr_blk(input int d, input logic [AW-1:0] a, input logic [BW-1:0] wd);
    txn(d, 1'b1, 1'b0, a, wd, '0, 1'b0, '0);
  endtask

  task automatic rd_blk(input int d, input logic [AW-1:0] a, input logic [BW-1:0] exp_rd);
    txn(d, 1'b0, 1'b1, a, '0, exp_rd, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_rd[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready_u%0d", d), ready[d], 1'b0);
      chk($sformatf("reset_perr_u%0d", d), perr[d], 1'b0);
      chk($sformatf("reset_rdc_u%0d", d), rdc[d], 16'd0);
      chk($sformatf("reset_wrc_u%0d", d), wrc[d], 16'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write then read at LATENCY 4.
    wr_blk(0, 28'h05, D0);
    chk("wr_count_1", wrc[0], 16'd1);
    rd_blk(0, 28'h05, D0);
    chk("rd_count_1", rdc[0], 16'd1);

    // Back-to-back write then fetch of the same block, no gap cycle.
    wr_blk(0, 28'h03, D1);
    rd_blk(0, 28'h03, D1);
    chk("no_perr_clean", perr[0], 1'b0);
    chk("wr_count_2", wrc[0], 16'd2);
    chk("rd_count_2", rdc[0], 16'd2);

    // Known contents at 0x07, then a write to 0x07 aborted by reset.
    wr_blk(0, 28'h07, D2);
    req_wr[0] = 1'b1; req_addr[0] = 28'h07; req_wdata[0] = D3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    req_wr[0] = 1'b0;
    #1;
    chk("async_rst_wrc", wrc[0], 16'd0);
    chk("async_rst_rdc", rdc[0], 16'd0);
    chk("async_rst_ready", ready[0], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd_blk(0, 28'h07, D2);
    chk("abort_rdc", rdc[0], 16'd1);
    chk("abort_wrc", wrc[0], 16'd0);

    // Read and write together: treated as a write, proto_err is sticky.
    txn(0, 1'b1, 1'b1, 28'h09, D4, '0, 1'b0, '0);
    chk("both_perr", perr[0], 1'b1);
    chk("both_is_write", wrc[0], 16'd1);
    rd_blk(0, 28'h09, D4);
    repeat (5) @(posedge clk);
    #1;
    chk("perr_sticky", perr[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("perr_cleared", perr[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Address change while busy: flagged, latched address still used.
    wr_blk(0, 28'h0B, D6);
    chk("perr_before_glitch", perr[0], 1'b0);
    txn(0, 1'b1, 1'b0, 28'h0A, D5, '0, 1'b1, 28'h0B);
    chk("glitch_perr", perr[0], 1'b1);
    rd_blk(0, 28'h0A, D5);
    rd_blk(0, 28'h0B, D6);

    // Aliasing: upper address bits ignored (0x105 -> index 0x05).
    rd_blk(0, 28'h105, D0);

    // LATENCY 1 instance.
    wr_blk(1, 28'h105, D7);
    rd_blk(1, 28'h05, D7);
    wr_blk(1, 28'h01, D1);
    rd_blk(1, 28'h01, D1);
    chk("lat1_wrc", wrc[1], 16'd2);
    chk("lat1_rdc", rdc[1], 16'd2);

    // LATENCY 15 instance.
    wr_blk(2, 28'h20, D8);
    rd_blk(2, 28'h120, D8);
    chk("lat15_rdc", rdc[2], 16'd1);
    chk("lat15_perr", perr[2], 1'b0);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("sb_drained_u%0d", d), sb[d].size(), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, meaning block-address width of the request bus.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 128, meaning data width of one block.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8, meaning storage holds 2^DEPTH_LOG2 blocks.
REQ-004 SHALL have parameter LATENCY, default 4, legal range 1..15, meaning cycles from request sample to mem_ready.
REQ-005 SHALL have port clk, input, 1, meaning the single clock (rising edge).
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port mem_read, input, 1, meaning block read request.
REQ-008 SHALL have port mem_write, input, 1, meaning block write request.
REQ-009 SHALL have port mem_addr, input, ADDR_WIDTH, meaning block address.
REQ-010 SHALL have port mem_wdata, input, BLOCK_WIDTH, meaning write data.
REQ-011 SHALL have port mem_rdata, output, BLOCK_WIDTH, meaning read data, valid only while mem_ready is high after a read.
REQ-012 SHALL have port mem_ready, output, 1, meaning one-cycle completion pulse.
REQ-013 SHALL have port proto_err, output, 1, meaning sticky protocol-violation flag.
REQ-014 SHALL have ports rd_count and wr_count, output, 16 each, meaning completed reads and completed writes.

Function
REQ-015 SHALL implement states IDLE, BUSY and RESP, all registered; mem_ready and mem_rdata SHALL be registered outputs.
REQ-016 In IDLE, a clk edge with mem_read or mem_write high SHALL latch op, mem_addr and mem_wdata and leave IDLE; with neither high it SHALL stay in IDLE.
REQ-017 With the request sampled at edge N, mem_ready SHALL be high exactly in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after sampling; LATENCY=1 SHALL go IDLE->RESP directly.
REQ-018 BUSY SHALL hold a 4-bit down-counter loaded with LATENCY-1 and SHALL move to RESP when the count reaches 1 (or immediately if loaded 0).
REQ-019 RESP SHALL last exactly one cycle and always return to IDLE; a request present during the first IDLE cycle after RESP SHALL be sampled with no gap cycle (supports back-to-back write-back then fetch).
REQ-020 Storage index SHALL be latched addr[DEPTH_LOG2-1:0]; upper address bits SHALL be ignored (aliasing).
REQ-021 Read: mem_rdata SHALL equal storage[index] during RESP; mem_rdata SHALL be 0 whenever mem_ready is low.
REQ-022 Write: storage[index] SHALL be updated with latched wdata on the edge entering RESP; a read of the same index issued after RESP SHALL return the new data.
REQ-023 mem_read and mem_write both high when sampled SHALL be treated as a write and SHALL set proto_err.
REQ-024 In BUSY, mem_addr differing from the latched address, or the latched op's request line low, SHALL set proto_err; the latched transaction SHALL still complete with the latched values and mem_ready SHALL still pulse.
REQ-025 proto_err SHALL be cleared only by rst.
REQ-026 rd_count and wr_count SHALL increment by 1 on each RESP of the matching op and SHALL saturate at 16'hFFFF.

Reset
REQ-027 rst high SHALL immediately force state IDLE, mem_ready 0, mem_rdata 0, proto_err 0, rd_count 0, wr_count 0 and counter 0, independent of clk.
REQ-028 rst asserted mid-transaction SHALL abort it: a pending write SHALL not reach storage and no mem_ready SHALL follow.
REQ-029 Storage contents SHALL not be altered by rst; blocks never written read as undefined.

Verification
REQ-030 LATENCY=4: write addr 0x05, data 0x0123..CDEF held; mem_ready single pulse 4 cycles after sample; wr_count=1.
REQ-031 Then read addr 0x05 -> mem_ready after 4 cycles with mem_rdata=0x0123..CDEF; mem_rdata=0 in all other cycles; rd_count=1.
REQ-032 Write 0x03 immediately followed by read 0x03 in the first cycle after RESP -> read sampled with no gap and returns the written data.
REQ-033 Read and write both high -> write performed, proto_err=1 and stays 1 until rst; address change in BUSY -> proto_err=1, latched address used.
REQ-034 rst pulsed two cycles into a write to 0x07 -> no mem_ready; later read of 0x07 returns its prior contents; counters read 0.
REQ-035 LATENCY=1 and LATENCY=15 builds -> mem_ready exactly 1 and 15 cycles after sample; addr 0x105 aliases to index 0x05 with DEPTH_LOG2=8.
